algo_cmos_16_8bit: RTL and testbench

ALGO_CMOS_16_8BIT -- requirements
Module: algo_cmos_16_8bit

---
 rtl/algo_cmos_16_8bit_if.sv | 14 +
 rtl/algo_cmos_16_8bit.sv | 104 ++++++++++
 tb/tb_algo_cmos_16_8bit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/algo_cmos_16_8bit_if.sv
// algo_cmos_16_8bit_if: pixel stream in (pix/pix_valid/pix_sof/pix_eol/pix_ready), byte stream out (pdata/de/fe/underrun)
interface algo_cmos_16_8bit_if;
  logic [15:0] pix;
  logic pix_valid;
  logic pix_sof;
  logic pix_eol;
  logic pix_ready;
  logic [7:0] pdata;
  logic de;
  logic fe;
  logic underrun;
  modport master (output pix, pix_valid, pix_sof, pix_eol, input pix_ready, pdata, de, fe, underrun);
  modport slave (input pix, pix_valid, pix_sof, pix_eol, output pix_ready, pdata, de, fe, underrun);
endinterface

// File: rtl/algo_cmos_16_8bit.sv
// algo_cmos_16_8bit: 16-bit pixels to 8-bit CMOS bytes with frame sync and line blanking (pclk, rst, bus slave: pix* in, pdata/de/fe/underrun out)
module algo_cmos_16_8bit #(
  parameter int FE_LEN = 4,
  parameter int FE_GAP = 8,
  parameter int H_BLANK = 16
) (
  input logic pclk,
  input logic rst,
  algo_cmos_16_8bit_if.slave bus
);
  localparam int MX = FE_LEN > FE_GAP ? (FE_LEN > H_BLANK ? FE_LEN : H_BLANK) : (FE_GAP > H_BLANK ? FE_GAP : H_BLANK);
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [2:0] {HI, LO, FSYNC, FGAP, HBLANK} state_t;
  state_t state;
  logic [17:0] mem [2];
  logic [17:0] head;
  logic [17:0] din;
  logic [1:0] count;
  logic [CW-1:0] counter;
  logic line_active;
  logic sof_done;
  logic push;
  logic pop;
  assign head = mem[0];
  assign din = {bus.pix, bus.pix_sof, bus.pix_eol};
  assign bus.pix_ready = ~rst & (count != 2'd2);
  assign push = bus.pix_valid & bus.pix_ready;
  assign pop = state == LO;
  always_ff @(posedge pclk) begin
    if (rst) count <= 2'd0;
    else count <= count + {1'b0, push} - {1'b0, pop};
    if (pop) mem[0] <= count[1] ? mem[1] : din;
    else if (push) mem[count[0]] <= din;
  end
  always_ff @(posedge pclk) begin
    if (rst) begin
      state <= HI;
      bus.pdata <= 8'd0;
      bus.de <= 1'b0;
      bus.fe <= 1'b0;
      bus.underrun <= 1'b0;
      counter <= '0;
      line_active <= 1'b0;
      sof_done <= 1'b0;
    end else begin
      case (state)
        HI: begin
          if (count == 2'd0) begin
            bus.de <= 1'b0;
            bus.pdata <= 8'd0;
            if (line_active) bus.underrun <= 1'b1;
          end else if (head[1] && !sof_done) begin
            bus.de <= 1'b0;
            bus.pdata <= 8'd0;
            bus.fe <= 1'b1;
            counter <= CW'(FE_LEN - 1);
            line_active <= 1'b0;
            state <= FSYNC;
          end else begin
            bus.pdata <= head[17:10];
            bus.de <= 1'b1;
            line_active <= 1'b1;
            state <= LO;
          end
        end
        LO: begin
          bus.pdata <= head[9:2];
          bus.de <= 1'b1;
          sof_done <= 1'b0;
          if (head[0]) begin
            line_active <= 1'b0;
            counter <= CW'(H_BLANK - 1);
            state <= HBLANK;
          end else state <= HI;
        end
        FSYNC: begin
          bus.de <= 1'b0;
          bus.pdata <= 8'd0;
          if (counter == '0) begin
            bus.fe <= 1'b0;
            counter <= CW'(FE_GAP > 1 ? FE_GAP - 2 : 0);
            sof_done <= FE_GAP == 1;
            state <= FE_GAP == 1 ? HI : FGAP;
          end else counter <= counter - 1'b1;
        end
        FGAP: begin
          bus.de <= 1'b0;
          bus.pdata <= 8'd0;
          if (counter == '0) begin
            sof_done <= 1'b1;
            state <= HI;
          end else counter <= counter - 1'b1;
        end
        HBLANK: begin
          bus.de <= 1'b0;
          bus.pdata <= 8'd0;
          if (counter == '0) state <= HI;
          else counter <= counter - 1'b1;
        end
        default: state <= HI;
      endcase
    end
  end
endmodule

// File: tb/tb_algo_cmos_16_8bit.sv
// tb_algo_cmos_16_8bit: directed scoreboard bench for algo_cmos_16_8bit
module tb_algo_cmos_16_8bit;
  logic pclk = 1'b0;
  logic rst = 1'b1;
  algo_cmos_16_8bit_if bus();
  algo_cmos_16_8bit dut (.pclk(pclk), .rst(rst), .bus(bus));
  always #5 pclk = ~pclk;
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int fe_len_q[$];
  int quiet_q[$];
  int de_run_q[$];
  int fe_cnt = 0;
  int de_cnt = 0;
  int quiet = 0;
  logic prev_de = 1'b0;
  logic prev_fe = 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clear();
    fe_len_q.delete();
    quiet_q.delete();
    de_run_q.delete();
  endtask
  task automatic send(input logic [15:0] p, input logic sof, input logic eol, input logic sb);
    bit ok = 1'b0;
    bus.pix = p;
    bus.pix_sof = sof;
    bus.pix_eol = eol;
    bus.pix_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (bus.pix_ready) begin
        @(posedge pclk);
        ok = 1'b1;
        if (sb) begin
          exp_q.push_back(p[15:8]);
          exp_q.push_back(p[7:0]);
        end
      end else @(negedge pclk);
    end
    chk("accept", 32'(ok), 32'd1);
    @(negedge pclk);
    bus.pix_valid = 1'b0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge pclk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    repeat (24) @(negedge pclk);
  endtask
  initial forever begin
    @(posedge pclk);
    #2;
    if (rst) begin
      prev_de = 1'b0;
      prev_fe = 1'b0;
      fe_cnt = 0;
      de_cnt = 0;
      quiet = 0;
    end else begin
      if (bus.de) begin
        if (exp_q.size() != 0) chk("byte", 32'(bus.pdata), 32'(exp_q.pop_front()));
        else chk("sb_depth", 32'(exp_q.size()), 32'd1);
      end else chk("pdata_idle", 32'(bus.pdata), 32'd0);
      if (bus.fe) fe_cnt++;
      else if (prev_fe) begin
        fe_len_q.push_back(fe_cnt);
        fe_cnt = 0;
      end
      if (bus.de) begin
        if (!prev_de) quiet_q.push_back(quiet);
        de_cnt++;
      end else if (prev_de) begin
        de_run_q.push_back(de_cnt);
        de_cnt = 0;
      end
      quiet = (bus.de || bus.fe) ? 0 : quiet + 1;
      prev_de = bus.de;
      prev_fe = bus.fe;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.pix = 16'd0;
    bus.pix_valid = 1'b0;
    bus.pix_sof = 1'b0;
    bus.pix_eol = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_pdata", 32'(bus.pdata), 32'd0);
    chk("rst_de", 32'(bus.de), 32'd0);
    chk("rst_fe", 32'(bus.fe), 32'd0);
    chk("rst_underrun", 32'(bus.underrun), 32'd0);
    chk("rst_ready", 32'(bus.pix_ready), 32'd0);
    rst = 1'b0;
    #1 chk("ready_after_rst", 32'(bus.pix_ready), 32'd1);
    @(negedge pclk);
    clear();
    send(16'hA1B2, 1'b0, 1'b0, 1'b1);
    send(16'hC3D4, 1'b0, 1'b1, 1'b1);
    send(16'h5566, 1'b0, 1'b0, 1'b1);
    send(16'h7788, 1'b0, 1'b1, 1'b1);
    repeat (4) @(negedge pclk);
    chk("ready_hblank", 32'(bus.pix_ready), 32'd0);
    wait_idle();
    chk("line1_run", 32'(de_run_q[0]), 32'd4);
    chk("hblank_gap", 32'(quiet_q[1]), 32'd16);
    chk("line2_run", 32'(de_run_q[1]), 32'd4);
    chk("no_underrun1", 32'(bus.underrun), 32'd0);
    clear();
    send(16'h1234, 1'b1, 1'b1, 1'b1);
    wait_idle();
    chk("fe_len", 32'(fe_len_q[0]), 32'd4);
    chk("fe_gap", 32'(quiet_q[0]), 32'd8);
    chk("sof_run", 32'(de_run_q[0]), 32'd2);
    chk("no_underrun2", 32'(bus.underrun), 32'd0);
    clear();
    send(16'h1111, 1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge pclk);
    chk("underrun_set", 32'(bus.underrun), 32'd1);
    chk("starved_de", 32'(bus.de), 32'd0);
    send(16'h2222, 1'b0, 1'b1, 1'b1);
    wait_idle();
    chk("starved_run", 32'(de_run_q[0]), 32'd2);
    chk("underrun_sticky", 32'(bus.underrun), 32'd1);
    send(16'hABCD, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'hAB);
    chk("lat_n_de", 32'(bus.de), 32'd0);
    bus.pix = 16'hBBBB;
    bus.pix_valid = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    bus.pix_valid = 1'b0;
    chk("lat_hi_de", 32'(bus.de), 32'd1);
    chk("lat_hi", 32'(bus.pdata), 32'hAB);
    rst = 1'b1;
    #1 chk("ready_in_rst", 32'(bus.pix_ready), 32'd0);
    @(negedge pclk);
    chk("mid_rst_pdata", 32'(bus.pdata), 32'd0);
    chk("mid_rst_de", 32'(bus.de), 32'd0);
    chk("mid_rst_fe", 32'(bus.fe), 32'd0);
    chk("mid_rst_underrun", 32'(bus.underrun), 32'd0);
    rst = 1'b0;
    #1 chk("ready_release", 32'(bus.pix_ready), 32'd1);
    repeat (10) @(negedge pclk);
    chk("flushed_de", 32'(bus.de), 32'd0);
    chk("flushed_ready", 32'(bus.pix_ready), 32'd1);
    chk("sb_after_rst", 32'(exp_q.size()), 32'd0);
    clear();
    send(16'h0101, 1'b0, 1'b0, 1'b1);
    send(16'h0202, 1'b1, 1'b1, 1'b1);
    wait_idle();
    chk("resync_run1", 32'(de_run_q[0]), 32'd2);
    chk("resync_fe_len", 32'(fe_len_q[0]), 32'd4);
    chk("resync_gap", 32'(quiet_q[1]), 32'd8);
    chk("resync_run2", 32'(de_run_q[1]), 32'd2);
    chk("resync_underrun", 32'(bus.underrun), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
